// File: rtl/fifo_defines_pkg.sv
// Shared widths and types for the FIFO / function-generator datapath.
// Includes the burst-sequencer FSM encoding and its default length width.
package fifo_defines_pkg;

  localparam int INT_BITS  = 16;
  localparam int SEQ_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONF = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fg_sample_counter.sv
// Saturating sample counter: clear, increment, terminal (cnt==len-1) and overflow flags.
// Zero-latency flags from the registered count; increments beyond len are refused and flagged.
module fg_sample_counter #(
  parameter int LEN_W = fifo_defines_pkg::SEQ_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             terminal,
  output logic             sat,
  output logic             ovf
);

  assign sat      = (cnt >= len);
  // Gated by !sat so len==0 cannot alias to an all-ones terminal value.
  assign terminal = !sat && (cnt == (len - LEN_W'(1)));
  assign ovf      = inc && sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/fg_burst_sequencer.sv
// Burst sequencer: command handshake -> configure -> run/hold on afull -> done pulse.
// RUN starts CONF_CYCLES+1 cycles after handshake; commands accepted only in IDLE.
module fg_burst_sequencer
  import fifo_defines_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int CONF_CYCLES = 1,
  parameter int INT_BITS    = fifo_defines_pkg::INT_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_sel_i,
  input  logic signed [INT_BITS-1:0] cmd_amp_i,
  input  logic [LEN_W-1:0]           cmd_len_i,
  input  logic                       abort_i,
  input  logic                       fifo_afull_i,
  input  logic                       fifo_full_i,
  input  logic                       gen_wr_en_i,
  output logic                       gen_en_low_o,
  output logic                       gen_enh_conf_o,
  output logic signed [INT_BITS-1:0] gen_amp_o,
  output logic [1:0]                 gen_sel_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       aborted_o,
  output logic [LEN_W-1:0]           sample_cnt_o,
  output logic                       overrun_o
);

  localparam int CW = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;

  seq_state_t       state, state_nxt;
  logic [CW-1:0]    conf_cnt;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             abort_set;
  logic             active;
  logic             cnt_inc;
  logic             cnt_terminal;
  logic             cnt_sat;
  logic             cnt_ovf;
  logic             overrun_set;

  assign accept  = cmd_valid_i && (state == IDLE);
  assign active  = (state == CONF) || (state == RUN) || (state == HOLD);
  assign cnt_inc = gen_wr_en_i && active;

  // Writes outside a burst, past the burst length, or into a full FIFO are all overruns.
  assign overrun_set = gen_wr_en_i &&
                       (fifo_full_i || cnt_ovf || (state == IDLE) || (state == DONE));

  fg_sample_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .inc      (cnt_inc),
    .len      (len_q),
    .cnt      (sample_cnt_o),
    .terminal (cnt_terminal),
    .sat      (cnt_sat),
    .ovf      (cnt_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      conf_cnt  <= '0;
      len_q     <= '0;
      gen_amp_o <= '0;
      gen_sel_o <= '0;
      aborted_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      conf_cnt <= (state == CONF) ? conf_cnt + CW'(1) : '0;
      if (accept) begin
        len_q     <= cmd_len_i;
        gen_amp_o <= cmd_amp_i;
        gen_sel_o <= cmd_sel_i;
      end
      if (accept) begin
        aborted_o <= 1'b0;
      end else if (abort_set) begin
        aborted_o <= 1'b1;
      end
      // A same-cycle overrun event is kept even when a new command clears the flag.
      overrun_o <= (accept ? 1'b0 : overrun_o) | overrun_set;
    end
  end

  always_comb begin
    state_nxt = state;
    abort_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (cmd_len_i == '0) ? DONE : CONF;
        end
      end
      CONF: begin
        if (abort_i) begin
          state_nxt = DONE;
          abort_set = 1'b1;
        end else if (conf_cnt == CW'(CONF_CYCLES - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = DONE;
          abort_set = 1'b1;
        end else if ((gen_wr_en_i && cnt_terminal) || cnt_sat) begin
          state_nxt = DONE;
        end else if (fifo_afull_i) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (abort_i) begin
          state_nxt = DONE;
          abort_set = 1'b1;
        end else if (!fifo_afull_i) begin
          state_nxt = RUN;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready_o    = (state == IDLE);
  assign gen_en_low_o   = (state != RUN);
  assign gen_enh_conf_o = (state == CONF);
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);

endmodule

// File: tb/tb_fg_burst_sequencer.sv
// Directed bench for fg_burst_sequencer with a CONF_CYCLES=1 and a CONF_CYCLES=3 instance.
module tb_fg_burst_sequencer;

  localparam int LEN_W = 16;
  localparam int IB    = 16;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [1:0] cmd_sel;
  logic signed [IB-1:0] cmd_amp;
  logic [LEN_W-1:0] cmd_len;
  logic abort, afull, full, wr_en;

  logic cmd_ready, en_low, enh_conf, busy, done, aborted, overrun;
  logic signed [IB-1:0] amp;
  logic [1:0] sel;
  logic [LEN_W-1:0] cnt;

  logic cmd_ready3, en_low3, enh_conf3, busy3, done3, aborted3, overrun3;
  logic signed [IB-1:0] amp3;
  logic [1:0] sel3;
  logic [LEN_W-1:0] cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fg_burst_sequencer #(.LEN_W(LEN_W), .CONF_CYCLES(1), .INT_BITS(IB)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_sel_i(cmd_sel), .cmd_amp_i(cmd_amp), .cmd_len_i(cmd_len), .abort_i(abort),
    .fifo_afull_i(afull), .fifo_full_i(full), .gen_wr_en_i(wr_en),
    .gen_en_low_o(en_low), .gen_enh_conf_o(enh_conf), .gen_amp_o(amp), .gen_sel_o(sel),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .sample_cnt_o(cnt), .overrun_o(overrun)
  );

  fg_burst_sequencer #(.LEN_W(LEN_W), .CONF_CYCLES(3), .INT_BITS(IB)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready3),
    .cmd_sel_i(cmd_sel), .cmd_amp_i(cmd_amp), .cmd_len_i(cmd_len), .abort_i(abort),
    .fifo_afull_i(afull), .fifo_full_i(full), .gen_wr_en_i(wr_en),
    .gen_en_low_o(en_low3), .gen_enh_conf_o(enh_conf3), .gen_amp_o(amp3), .gen_sel_o(sel3),
    .busy_o(busy3), .done_o(done3), .aborted_o(aborted3), .sample_cnt_o(cnt3), .overrun_o(overrun3)
  );

  // Outputs are sampled 1 time unit after the edge they reflect.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic signed [IB-1:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1; cmd_sel = s; cmd_amp = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++; if (en_low !== 1'b1) begin errors++; $display("FAIL reset_en_low got=%0d want=1", en_low); end
    checks++; if (enh_conf !== 1'b0) begin errors++; $display("FAIL reset_enh_conf got=%0d want=0", enh_conf); end
    checks++; if ({busy, done, aborted, overrun} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b want=0000", {busy, done, aborted, overrun}); end
    checks++; if (cnt !== 16'd0 || amp !== 16'sd0 || sel !== 2'd0) begin errors++; $display("FAIL reset_regs got cnt=%0d amp=%0d sel=%0d want 0/0/0", cnt, amp, sel); end
    rst = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0d want=1", cmd_ready); end
  endtask

  task automatic test_basic;
    send(2'd2, 16'sd3, 16'd4);
    checks++; if ({enh_conf, en_low, busy} !== 3'b111) begin errors++; $display("FAIL basic_conf got=%b want=111", {enh_conf, en_low, busy}); end
    checks++; if (amp !== 16'sd3 || sel !== 2'd2) begin errors++; $display("FAIL basic_latch got amp=%0d sel=%0d want 3/2", amp, sel); end
    tick();
    checks++; if ({enh_conf, en_low} !== 2'b00) begin errors++; $display("FAIL basic_run got=%b want=00", {enh_conf, en_low}); end
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      if (i < 4) begin
        checks++; if (done !== 1'b0 || cnt !== 16'(i) || en_low !== 1'b0) begin errors++; $display("FAIL basic_count got done=%0d cnt=%0d en_low=%0d want 0/%0d/0", done, cnt, en_low, i); end
      end
    end
    checks++; if ({done, aborted, en_low} !== 3'b101 || cnt !== 16'd4) begin errors++; $display("FAIL basic_done got flags=%b cnt=%0d want 101/4", {done, aborted, en_low}, cnt); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got=%0d want=0", cmd_ready); end
    tick();
    checks++; if ({done, cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL basic_idle got=%b want=010", {done, cmd_ready, busy}); end
    checks++; if (amp !== 16'sd3 || sel !== 2'd2) begin errors++; $display("FAIL basic_hold_latch got amp=%0d sel=%0d want 3/2", amp, sel); end
  endtask

  task automatic test_len0;
    send(2'd1, 16'sd5, 16'd0);
    checks++; if ({done, en_low, enh_conf} !== 3'b110 || cnt !== 16'd0) begin errors++; $display("FAIL len0_done got flags=%b cnt=%0d want 110/0", {done, en_low, enh_conf}, cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL len0_overrun_clear got=%0d want=0", overrun); end
    tick();
    checks++; if ({done, cmd_ready, enh_conf, en_low} !== 4'b0101) begin errors++; $display("FAIL len0_idle got=%b want=0101", {done, cmd_ready, enh_conf, en_low}); end
  endtask

  task automatic test_afull;
    send(2'd0, 16'sd7, 16'd10);
    tick();
    for (int i = 0; i < 3; i++) begin wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    afull = 1'b1;
    tick();
    checks++; if ({en_low, busy} !== 2'b11 || cnt !== 16'd3) begin errors++; $display("FAIL afull_hold got flags=%b cnt=%0d want 11/3", {en_low, busy}, cnt); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (en_low !== 1'b1) begin errors++; $display("FAIL afull_still_hold got=%0d want=1", en_low); end
    afull = 1'b0;
    tick();
    checks++; if (en_low !== 1'b0) begin errors++; $display("FAIL afull_resume got=%0d want=0", en_low); end
    for (int i = 0; i < 7; i++) begin wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    checks++; if ({done, aborted} !== 2'b10 || cnt !== 16'd10) begin errors++; $display("FAIL afull_done got flags=%b cnt=%0d want 10/10", {done, aborted}, cnt); end
    tick();
  endtask

  task automatic test_abort;
    send(2'd3, -16'sd2, 16'd8);
    tick();
    for (int i = 0; i < 5; i++) begin wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({done, aborted} !== 2'b11 || cnt !== 16'd5) begin errors++; $display("FAIL abort_done got flags=%b cnt=%0d want 11/5", {done, aborted}, cnt); end
    tick();
    checks++; if ({cmd_ready, done} !== 2'b10) begin errors++; $display("FAIL abort_ready got=%b want=10", {cmd_ready, done}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle_ignored got=%b want=00", {busy, done}); end
  endtask

  task automatic test_overrun;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (overrun !== 1'b1 || cnt !== 16'd5) begin errors++; $display("FAIL ovr_idle got ovr=%0d cnt=%0d want 1/5", overrun, cnt); end
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0d want=1", overrun); end
    send(2'd1, 16'sd1, 16'd6);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%0d want=0", overrun); end
    tick();
    wr_en = 1'b1; full = 1'b1;
    tick();
    wr_en = 1'b0; full = 1'b0;
    checks++; if (overrun !== 1'b1 || cnt !== 16'd1) begin errors++; $display("FAIL ovr_full got ovr=%0d cnt=%0d want 1/1", overrun, cnt); end
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_full_sticky got=%0d want=1", overrun); end
    abort = 1'b1; tick(); abort = 1'b0; tick();
    send(2'd0, 16'sd0, 16'd0);
    checks++; if (overrun !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ovr_clear2 got ovr=%0d done=%0d want 0/1", overrun, done); end
    tick();
  endtask

  task automatic test_reset_mid;
    send(2'd2, 16'sd9, 16'd6);
    tick();
    for (int i = 0; i < 2; i++) begin wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    checks++; if (cnt !== 16'd2 || en_low !== 1'b0) begin errors++; $display("FAIL rstmid_pre got cnt=%0d en_low=%0d want 2/0", cnt, en_low); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if ({busy, done, en_low, enh_conf} !== 4'b0010 || cnt !== 16'd0 || amp !== 16'sd0 || sel !== 2'd0) begin errors++; $display("FAIL rstmid_vals got flags=%b cnt=%0d amp=%0d sel=%0d want 0010/0/0/0", {busy, done, en_low, enh_conf}, cnt, amp, sel); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone got=%b want=00", {done, busy}); end
  endtask

  task automatic test_conf3;
    int hi;
    hi = 0;
    send(2'd1, 16'sd4, 16'd2);
    for (int k = 1; k <= 5; k++) begin
      if (enh_conf3 === 1'b1) hi++;
      if (k == 3) begin
        checks++; if ({enh_conf3, en_low3} !== 2'b11) begin errors++; $display("FAIL conf3_last got=%b want=11", {enh_conf3, en_low3}); end
      end
      if (k == 4) begin
        checks++; if ({enh_conf3, en_low3} !== 2'b00) begin errors++; $display("FAIL conf3_run got=%b want=00", {enh_conf3, en_low3}); end
      end
      tick();
    end
    checks++; if (hi !== 3) begin errors++; $display("FAIL conf3_cycles got=%0d want=3", hi); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if ({done3, aborted3} !== 2'b11) begin errors++; $display("FAIL conf3_abort got=%b want=11", {done3, aborted3}); end
    tick();
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_amp = '0; cmd_len = '0;
    abort = 1'b0; afull = 1'b0; full = 1'b0; wr_en = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_afull();
    test_abort();
    test_overrun();
    test_reset_mid();
    test_conf3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fg_burst_sequencer.md
Name: fg_burst_sequencer

Overview:
- Sequences the function generator: accepts a burst command (waveform, amplitude, sample count) over a valid/ready handshake.
- Drives the generator's configure/enable controls, counts the samples it writes into the FIFO, and pauses generation on FIFO almost-full.
- Sits between the host/register interface and funct_generator; it is the only master of the generator's en_low_i, enh_conf_i, amp_i and sel_i.

Parameters:
- LEN_W, 16, width of burst length and sample counter.
- CONF_CYCLES, 1, cycles enh_conf held high in CONF (>=1).
- INT_BITS, fifo_defines_pkg::INT_BITS, amplitude width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_sel_i  in  2  waveform select (cos/sin/triangle/square)
- cmd_amp_i  in  INT_BITS  signed amplitude
- cmd_len_i  in  LEN_W  samples to produce
- abort_i  in  1  terminate current burst
- fifo_afull_i  in  1  FIFO almost-full
- fifo_full_i  in  1  FIFO full
- gen_wr_en_i  in  1  generator wr_en_o (one sample written)
- gen_en_low_o  out  1  generator hold-in-IDLE
- gen_enh_conf_o  out  1  generator configure request
- gen_amp_o  out  INT_BITS  latched amplitude
- gen_sel_o  out  2  latched select
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at burst end
- aborted_o  out  1  qualifies done_o: burst ended by abort
- sample_cnt_o  out  LEN_W  samples counted in current/last burst
- overrun_o  out  1  sticky: unexpected sample or write while full

Behaviour:
- Reset (rst==0 at posedge): state IDLE; gen_en_low_o=1; gen_enh_conf_o=0; gen_amp_o=0; gen_sel_o=0; busy_o=0; done_o=0; aborted_o=0; sample_cnt_o=0; overrun_o=0; conf counter=0. Reset mid-burst abandons the burst with no done_o.
- States: IDLE, CONF, RUN, HOLD, DONE.
- IDLE:
  - cmd_ready_o=1, gen_en_low_o=1.
  - On handshake: latch sel/amp/len; clear sample_cnt_o and overrun_o.
  - len!=0 -> CONF; len==0 -> DONE (no generator activity).
- CONF:
  - gen_enh_conf_o=1, gen_en_low_o=1 for exactly CONF_CYCLES cycles, then RUN.
  - gen_amp_o and gen_sel_o remain stable from CONF entry until return to IDLE.
- RUN:
  - gen_en_low_o=0, gen_enh_conf_o=0.
  - fifo_afull_i=1 -> HOLD next cycle.
  - Terminal sample (gen_wr_en_i while sample_cnt_o==len-1) -> DONE; gen_en_low_o=1 in DONE.
  - If afull and the terminal sample coincide, DONE wins.
- HOLD:
  - gen_en_low_o=1.
  - Returns to RUN the cycle after fifo_afull_i deasserts.
  - Resume restarts waveform phase at LUT address 0 (generator re-enters GEN via IDLE); this is specified system behaviour.
- DONE: one cycle; done_o=1; aborted_o valid; then IDLE. The next command is accepted no earlier than the cycle after DONE.
- Counting:
  - sample_cnt_o increments on gen_wr_en_i in CONF/RUN/HOLD while below len; it saturates at len.
  - gen_wr_en_i with sample_cnt_o==len, or in IDLE/DONE -> overrun_o=1 (counter unchanged).
  - gen_wr_en_i && fifo_full_i in any state -> overrun_o=1.
  - overrun_o clears only on reset or next command accept.
- Abort:
  - abort_i in CONF/RUN/HOLD -> DONE next cycle with aborted_o=1; sample_cnt_o holds the partial count.
  - abort_i in IDLE/DONE is ignored; abort_i has priority over terminal sample and afull.
- Latency: handshake at cycle t -> CONF t+1..t+CONF_CYCLES -> RUN at t+CONF_CYCLES+1.

Decomposition:
- Add to fifo_defines_pkg: seq_state_t enum {IDLE, CONF, RUN, HOLD, DONE} (3-bit), SEQ_LEN_W=16.
- One sub-module, fg_sample_counter: saturating LEN_W counter with clear, increment, terminal flag (cnt==len-1) and overflow detect.
- FSM, latches and outputs stay in fg_burst_sequencer.

Test Plan:
- Reset then len=4, sel=2, amp=3 handshake at t0: CONF at t1, RUN at t2; four gen_wr_en_i pulses; DONE on the cycle after the 4th pulse; done_o=1, aborted_o=0, sample_cnt_o=4; gen_amp_o=3, gen_sel_o=2 held throughout.
- len=0 command: DONE next cycle, done_o=1, sample_cnt_o=0, gen_en_low_o stays 1, gen_enh_conf_o never asserted.
- len=10, fifo_afull_i high after 3 samples for 5 cycles: HOLD with gen_en_low_o=1 the cycle after afull; RUN the cycle after afull drops; finishes with sample_cnt_o=10.
- len=8, abort_i after 5 samples: DONE next cycle, aborted_o=1, sample_cnt_o=5; cmd_ready_o=1 the following cycle.
- gen_wr_en_i pulsed in IDLE, and again with fifo_full_i=1 during RUN: overrun_o=1 sticky; the next command accept clears it to 0.
- rst low mid-RUN (len=6, 2 samples): all outputs at reset values next cycle, no done_o; CONF_CYCLES=3 rerun shows gen_enh_conf_o high exactly 3 cycles.
